lock_ctrl_fsm: RTL and testbench

Downstream consumer of the six-digit password comparator. It sequences one check per user confirm: it drives the comparator enable, samples the match result, then opens the lock, counts failures, enters a timed alarm lockout, or writes a new password.
It sits between the keypad/entry logic (confirm strobes) and the actuator, LED and buzzer outputs.

---
 rtl/lock_ctrl_fsm.sv | 153 +++++++++++++++
 tb/tb_lock_ctrl_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl_fsm.sv
// rtl/lock_ctrl_fsm.sv - lock controller sequencing password checks, open/relock, lockout
// Optional macro ALARM_ACK_EN: lockout holds after expiry until an alarm_ack strobe.
module lock_ctrl_fsm #(
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 1000,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirm,
  input  logic       match,
  input  logic       lock_cmd,
  input  logic       set_pw_req,
`ifdef ALARM_ACK_EN
  input  logic       alarm_ack,
`endif
  output logic       judge_en,
  output logic       unlocked,
  output logic       fail_pulse,
  output logic       alarm,
  output logic       store_pw,
  output logic [2:0] err_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_EVAL    = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_SETPW   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       MAX_ERR   = 3'(MAX_TRIES);
  localparam logic [3:0]       MAX_ERR4  = 4'(MAX_TRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       err_q, err_d;
  logic             judge_en_q, judge_en_d;
  logic             unlocked_q, unlocked_d;
  logic             fail_pulse_q, fail_pulse_d;
  logic             alarm_q, alarm_d;
  logic             store_pw_q, store_pw_d;

  logic             timer_zero;
  logic [CNT_W-1:0] timer_dec;
  logic [3:0]       err_inc;
  logic             lock_exit;

  always_comb begin
    timer_zero = (timer_q == '0);
    timer_dec  = timer_zero ? '0 : (timer_q - CNT_ONE);
    err_inc    = {1'b0, err_q} + 4'd1;
`ifdef ALARM_ACK_EN
    lock_exit  = timer_zero && alarm_ack;
`else
    lock_exit  = timer_zero;
`endif
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (confirm) state_d = S_CHECK;
      end
      S_CHECK: state_d = S_EVAL;
      S_EVAL: begin
        if (match) begin
          state_d = S_OPEN;
          err_d   = 3'd0;
          timer_d = OPEN_LOAD;
        end else if (err_inc >= MAX_ERR4) begin
          state_d = S_LOCKOUT;
          err_d   = MAX_ERR;
          timer_d = LOCK_LOAD;
        end else begin
          state_d = S_FAIL;
          err_d   = err_inc[2:0];
        end
      end
      S_FAIL: state_d = S_IDLE;
      S_OPEN: begin
        timer_d = timer_dec;
        // relock beats password write, which beats natural expiry
        if (lock_cmd)                     state_d = S_IDLE;
        else if (confirm && set_pw_req)   state_d = S_SETPW;
        else if (timer_zero)              state_d = S_IDLE;
      end
      S_SETPW: begin
        state_d = S_OPEN;
        timer_d = OPEN_LOAD;
      end
      S_LOCKOUT: begin
        timer_d = timer_dec;
        if (lock_exit) begin
          state_d = S_IDLE;
          err_d   = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    judge_en_d   = (state_d == S_CHECK) || (state_d == S_EVAL);
    unlocked_d   = (state_d == S_OPEN) || (state_d == S_SETPW);
    fail_pulse_d = (state_d == S_FAIL);
    alarm_d      = (state_d == S_LOCKOUT);
    store_pw_d   = (state_d == S_SETPW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      err_q        <= 3'd0;
      judge_en_q   <= 1'b0;
      unlocked_q   <= 1'b0;
      fail_pulse_q <= 1'b0;
      alarm_q      <= 1'b0;
      store_pw_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      judge_en_q   <= judge_en_d;
      unlocked_q   <= unlocked_d;
      fail_pulse_q <= fail_pulse_d;
      alarm_q      <= alarm_d;
      store_pw_q   <= store_pw_d;
    end
  end

  assign judge_en   = judge_en_q;
  assign unlocked   = unlocked_q;
  assign fail_pulse = fail_pulse_q;
  assign alarm      = alarm_q;
  assign store_pw   = store_pw_q;
  assign err_cnt    = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// tb/tb_lock_ctrl_fsm.sv - randomized bench for lock_ctrl_fsm against a cycle-count reference model
module tb_lock_ctrl_fsm;

  localparam int MAXT   = 3;
  localparam int OPEN_N = 8;
  localparam int LOCK_N = 16;

  localparam int M_IDLE = 0, M_CHECK = 1, M_EVAL = 2, M_OPEN = 3;
  localparam int M_FAIL = 4, M_LOCKOUT = 5, M_SETPW = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       confirm = 1'b0;
  logic       match = 1'b0;
  logic       lock_cmd = 1'b0;
  logic       set_pw_req = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       judge_en, unlocked, fail_pulse, alarm, store_pw;
  logic [2:0] err_cnt, state_o;

  always #5 clk = ~clk;

  lock_ctrl_fsm #(
    .MAX_TRIES(MAXT),
    .OPEN_CYCLES(OPEN_N),
    .LOCKOUT_CYCLES(LOCK_N),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .confirm(confirm),
    .match(match),
    .lock_cmd(lock_cmd),
    .set_pw_req(set_pw_req),
`ifdef ALARM_ACK_EN
    .alarm_ack(alarm_ack),
`endif
    .judge_en(judge_en),
    .unlocked(unlocked),
    .fail_pulse(fail_pulse),
    .alarm(alarm),
    .store_pw(store_pw),
    .err_cnt(err_cnt),
    .state_o(state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current mode plus cycles still left in the open / lockout window.
  int mode, errs, open_left, lock_left;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("judge_en",   judge_en,   (mode == M_CHECK) || (mode == M_EVAL));
    check_eq("unlocked",   unlocked,   (mode == M_OPEN) || (mode == M_SETPW));
    check_eq("fail_pulse", fail_pulse, mode == M_FAIL);
    check_eq("alarm",      alarm,      mode == M_LOCKOUT);
    check_eq("store_pw",   store_pw,   mode == M_SETPW);
    check_eq("err_cnt",    err_cnt,    errs);
    check_eq("state_o",    state_o,    mode);
  endtask

  task automatic model_reset();
    mode = M_IDLE; errs = 0; open_left = 0; lock_left = 0;
  endtask

  task automatic model_advance(input logic c, input logic m, input logic l,
                               input logic s, input logic a);
    case (mode)
      M_IDLE:  if (c) mode = M_CHECK;
      M_CHECK: mode = M_EVAL;
      M_EVAL: begin
        if (m) begin
          mode = M_OPEN; errs = 0; open_left = OPEN_N;
        end else if (errs + 1 == MAXT) begin
          mode = M_LOCKOUT; errs = MAXT; lock_left = LOCK_N;
        end else begin
          mode = M_FAIL; errs = errs + 1;
        end
      end
      M_FAIL: mode = M_IDLE;
      M_OPEN: begin
        if (l)                mode = M_IDLE;
        else if (c && s)      mode = M_SETPW;
        else if (open_left == 1) mode = M_IDLE;
        else                  open_left = open_left - 1;
      end
      M_SETPW: begin
        mode = M_OPEN; open_left = OPEN_N;
      end
      M_LOCKOUT: begin
`ifdef ALARM_ACK_EN
        if (lock_left <= 1) begin
          lock_left = 1;
          if (a) begin mode = M_IDLE; errs = 0; end
        end else lock_left = lock_left - 1;
`else
        if (lock_left == 1) begin mode = M_IDLE; errs = 0; end
        else lock_left = lock_left - 1;
`endif
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic step(input logic c, input logic m, input logic l,
                      input logic s, input logic a);
    @(negedge clk);
    check_outputs();
    confirm = c; match = m; lock_cmd = l; set_pw_req = s; alarm_ack = a;
    model_advance(c, m, l, s, a);
  endtask

  task automatic run_check(input logic m);
    step(1'b1, m, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, m, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // open and let the timer expire
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // two failures then a success
    run_check(1'b0);
    run_check(1'b0);
    run_check(1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // three failures into lockout, confirm ignored inside lockout
    run_check(1'b0);
    run_check(1'b0);
    run_check(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // lock_cmd wins over set-password; then a real password write
    run_check(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_check(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // confirm during EVAL is dropped
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic c, m, l, s, a;
      c = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 1) == 0);
      a = ($urandom_range(0, 7) == 0);
      step(c, m, l, s, a);
    end

    // drain to IDLE, drive into lockout, then reset asynchronously mid-lockout
    repeat (40) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      if (mode != M_LOCKOUT) run_check(1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_alarm", alarm, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_alarm",    alarm,    0);
    check_eq("async_unlocked", unlocked, 0);
    check_eq("async_err_cnt",  err_cnt,  0);
    check_eq("async_state",    state_o,  0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    confirm = 1'b0; match = 1'b0; lock_cmd = 1'b0; set_pw_req = 1'b0; alarm_ack = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_check(1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
